// File: rtl/pulse_interval_meter_if.sv
// Result handshake bundle for pulse_interval_meter.
// The master drives the measured interval and its flags; the slave supplies ready.
interface pulse_interval_meter_if #(
    parameter int CNT_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_interval;
    logic             out_ovf;
    logic             out_lost;

    modport master (
        output out_valid,
        output out_interval,
        output out_ovf,
        output out_lost,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_interval,
        input  out_ovf,
        input  out_lost,
        output out_ready
    );
endinterface

// File: rtl/pulse_interval_meter.sv
// Measures cycles between accepted pulses and offers each interval on a valid/ready port.
// Optional PULSE_MINGAP_EN rejects pulses arriving less than MIN_GAP cycles apart.
module pulse_interval_meter #(
    parameter int CNT_W   = 16,
    parameter int MIN_GAP = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  pulse,
    pulse_interval_meter_if.master res,
    output logic [15:0]           pulse_count,
    output logic [7:0]            rej_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             accept;
    logic             load;
    logic             gap_ok;

    logic             valid_q;
    logic [CNT_W-1:0] interval_q;
    logic             rovf_q;
    logic             lost_q;
    logic [15:0]      pcnt_q;

`ifdef PULSE_MINGAP_EN
    localparam logic [CNT_W-1:0] GAP = CNT_W'(MIN_GAP);

    logic       reject;
    logic [7:0] rcnt_q;

    assign gap_ok = (cnt_q >= GAP);
    assign reject = en && pulse && (state_q == MEASURE) && !gap_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q <= '0;
        end else if (reject && (rcnt_q != 8'hFF)) begin
            rcnt_q <= rcnt_q + 8'd1;
        end
    end

    assign rej_count = rcnt_q;
`else
    assign gap_ok    = 1'b1;
    assign rej_count = 8'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Disabling drops any partial interval and the reference pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;
        load    = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pulse) begin
                        accept  = 1'b1;
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                        ovf_d   = 1'b0;
                    end
                end
                MEASURE: begin
                    if (pulse && gap_ok) begin
                        accept = 1'b1;
                        load   = 1'b1;
                        cnt_d  = CNT_ONE;
                        ovf_d  = 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // A load wins over a handshake; an unread overwrite marks the loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            interval_q <= '0;
            rovf_q     <= 1'b0;
            lost_q     <= 1'b0;
        end else if (load) begin
            valid_q    <= 1'b1;
            interval_q <= cnt_q;
            rovf_q     <= ovf_q;
            if (valid_q && !res.out_ready) begin
                lost_q <= 1'b1;
            end
        end else if (valid_q && res.out_ready) begin
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (accept) begin
            pcnt_q <= pcnt_q + 16'd1;
        end
    end

    assign res.out_valid    = valid_q;
    assign res.out_interval = interval_q;
    assign res.out_ovf      = rovf_q;
    assign res.out_lost     = lost_q;
    assign pulse_count      = pcnt_q;

endmodule
